// File: rtl/spi_slave_if.sv
// SPI slave front-end: deserialises MSB-first command frames from MOSI into rx_data,
// and serialises the RAM read response onto MISO for read-data transactions.
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int BIT_CW = $clog2(FRAME_W + 1);
  localparam int TX_CW  = $clog2(DATA_W + 2);
  localparam logic [BIT_CW-1:0] BITS_LAST = BIT_CW'(FRAME_W - 1);
  localparam logic [BIT_CW-1:0] BITS_FULL = BIT_CW'(FRAME_W);
  localparam logic [TX_CW-1:0]  TX_LAST   = TX_CW'(DATA_W);
  localparam logic [TX_CW-1:0]  TX_DONE   = TX_CW'(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [FRAME_W-2:0]  r_shift;
  logic [BIT_CW-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [TX_CW-1:0]    r_tx_cnt;
  logic                r_rd_addr_seen;
  logic                w_frame_done;
  logic                w_last_bit;

  assign w_frame_done = (r_bit_cnt == BITS_FULL);
  assign w_last_bit   = (r_bit_cnt == BITS_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!SS_n) w_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                w_next = IDLE;
        else if (!MOSI)          w_next = WRITE;
        else if (r_rd_addr_seen) w_next = READ_DATA;
        else                     w_next = READ_ADD;
      end
      default: if (SS_n) w_next = IDLE;
    endcase
  end

  // The CHK_CMD edge samples frame bit 9; subsequent states keep shifting until the frame is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_rd_addr_seen <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      MISO           <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (r_state == IDLE || SS_n) begin
        r_bit_cnt <= '0;
        r_tx_cnt  <= '0;
        MISO      <= 1'b0;
      end else if (!w_frame_done) begin
        r_shift   <= {r_shift[FRAME_W-3:0], MOSI};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_last_bit) begin
          rx_data  <= {r_shift, MOSI};
          rx_valid <= 1'b1;
          if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
        end
      end else if (r_state == READ_DATA) begin
        // r_tx_cnt: 0 awaiting response, 1..DATA_W shifting out, DATA_W+1 finished.
        if (r_tx_cnt == '0) begin
          if (tx_valid) begin
            MISO       <= tx_data[DATA_W-1];
            r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
            r_tx_cnt   <= TX_CW'(1);
          end
        end else if (r_tx_cnt < TX_LAST) begin
          MISO       <= r_tx_shift[DATA_W-1];
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          r_tx_cnt   <= r_tx_cnt + 1'b1;
        end else if (r_tx_cnt == TX_LAST) begin
          MISO           <= 1'b0;
          r_tx_cnt       <= TX_DONE;
          r_rd_addr_seen <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if against a transaction-level model of frames,
// the read-address flag and the MISO response stream.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last completed frame and whether a read address is pending.
  logic [9:0] exp_rx   = '0;
  bit         exp_seen = 1'b0;

  spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_checks += 3;
    if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b want=0", MISO); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data got=%h want=000", rx_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sends nbits of frame f (MSB first), then pulses tx_valid with txd and checks the MISO stream.
  // Frames shorter than 10 bits are aborted by raising SS_n.
  task automatic run_frame(input logic [9:0] f, input int nbits, input logic [7:0] txd);
    bit read_data;
    read_data = f[9] && exp_seen;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_early bit=%0d got=%b want=0", i, rx_valid); end
      if (MISO !== 1'b0) begin n_fail++; $display("FAIL miso_during_rx bit=%0d got=%b want=0", i, MISO); end
      MOSI = f[9-i];
    end
    if (nbits < 10) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'($urandom);
      repeat (3) begin
        @(negedge clk);
        n_checks += 2;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid got=%b want=0", rx_valid); end
        if (rx_data !== exp_rx) begin n_fail++; $display("FAIL abort_rx_data got=%h want=%h", rx_data, exp_rx); end
      end
      return;
    end
    @(negedge clk);
    exp_rx = f;
    if (f[9] && !exp_seen) exp_seen = 1'b1;
    n_checks += 2;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_pulse got=%b want=1", rx_valid); end
    if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rx_data got=%h want=%h", rx_data, exp_rx); end
    MOSI = 1'($urandom);
    @(negedge clk);
    n_checks += 3;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_width got=%b want=0", rx_valid); end
    if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rx_data_hold got=%h want=%h", rx_data, exp_rx); end
    if (MISO !== 1'b0) begin n_fail++; $display("FAIL miso_before_tx got=%b want=0", MISO); end
    tx_valid = 1'b1;
    tx_data  = txd;
    @(negedge clk);
    for (int k = 7; k >= 0; k--) begin
      n_checks++;
      if (MISO !== (read_data ? txd[k] : 1'b0))
        begin n_fail++; $display("FAIL miso_bit%0d got=%b want=%b", k, MISO, read_data ? txd[k] : 1'b0); end
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      MOSI     = 1'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (read_data) exp_seen = 1'b0;
    n_checks++;
    if (MISO !== 1'b0) begin n_fail++; $display("FAIL miso_after_tx got=%b want=0", MISO); end
    SS_n = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (MISO !== 1'b0) begin n_fail++; $display("FAIL miso_idle got=%b want=0", MISO); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_idle got=%b want=0", rx_valid); end
  endtask

  task automatic test_directed();
    run_frame(10'h03C, 10, 8'h5A);
    run_frame(10'h1A5, 10, 8'hFF);
    run_frame(10'h23C, 10, 8'h3C);
    run_frame({2'b11, 8'($urandom)}, 10, 8'hA5);
  endtask

  task automatic test_abort();
    run_frame(10'($urandom), 5, 8'h00);
    run_frame(10'h2F0, 10, 8'hC3);
    run_frame(10'h3FF, 10, 8'h96);
  endtask

  task automatic test_reset_mid_serial();
    run_frame(10'h2AA, 10, 8'h00);
    // A pending read address now exists, so this frame enters read-data serialisation.
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); MOSI = (i == 0); end
    repeat (2) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MISO !== 1'b1) begin n_fail++; $display("FAIL miso_serial_pre_reset got=%b want=1", MISO); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_mid_miso got=%b want=0", MISO); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_rx_valid got=%b want=0", rx_valid); end
    if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_mid_rx_data got=%h want=000", rx_data); end
    SS_n = 1'b1;
    exp_seen = 1'b0;
    exp_rx   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(10'h300, 10, 8'hE7);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_frame(10'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10, 8'($urandom));
  endtask

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_serial();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
